// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer.
// Holds the state codes, opcode values, instruction field positions
// and the strobe bundle passed from the decoder to the top level.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LD  = 2'b01,
    OP_ST  = 2'b10,
    OP_JMP = 2'b11
  } op_t;

  // Instruction field bit positions: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm
  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int RS_HI = 5;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 2;
  localparam int RD_HI = 1;
  localparam int RD_LO = 0;

  typedef struct packed {
    logic ir_write;
    logic pc_write;
    logic pc_src;
    logic alusrc;
    logic regdst;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } strobes_t;

  function automatic logic is_mem_op(input op_t op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational Moore-output decoder for the control sequencer.
// Ports:
//   state : current sequencer state
//   op_q  : opcode latched in DECODE
//   strb  : datapath strobe bundle (PC, IR, ALU, register file, data memory)
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t   state,
  input  op_t      op_q,
  output strobes_t strb
);

  always_comb begin
    strb = '0;
    case (state)
      S_FETCH: begin
        strb.ir_write = 1'b1;
        strb.pc_write = 1'b1;
        strb.pc_src   = 1'b0;
      end
      S_EXEC: begin
        strb.alusrc = is_mem_op(op_q);
        if (op_q == OP_JMP) begin
          strb.pc_write = 1'b1;
          strb.pc_src   = 1'b1;
        end
      end
      S_MEM: begin
        // Address is still rs + imm, so keep the immediate on ALU B
        strb.alusrc   = 1'b1;
        strb.memread  = (op_q == OP_LD);
        strb.memwrite = (op_q == OP_ST);
      end
      S_WB: begin
        // Only ADD and LD ever reach WB
        strb.regwrite = 1'b1;
        strb.regdst   = (op_q == OP_ADD);
        strb.memtoreg = (op_q == OP_LD);
      end
      default: strb = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit, four-register CPU.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and
// drives the PC, IR, ALU, register-file and data-memory strobes.
// Ports:
//   CLK, RST        : clock, asynchronous active-high reset
//   run             : level, allows new fetches to start
//   instr           : IR contents, valid from DECODE onward
//   mem_ready       : data-memory completion, sampled in MEM
//   ir_write .. memtoreg : datapath strobes (Moore decode of state/op)
//   busy            : high in every state except IDLE
//   err             : sticky memory-timeout flag, blocks fetches
//   retired         : count of completed instructions (wraps)
//   state           : current state code for debug
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [7:0]       instr,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alusrc,
  output logic             regdst,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int WAIT_W = ($clog2(MEM_TIMEOUT) > 0) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  op_t               op_q;
  logic [WAIT_W-1:0] wait_cnt;
  strobes_t          strb;

  // Register fields are consumed by the datapath, not by the sequencer
  logic unused_fields;
  assign unused_fields = ^instr[RS_HI:RD_LO];

  // State after an instruction completes
  function automatic state_t after_complete(input logic run_i);
    return run_i ? S_FETCH : S_IDLE;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      wait_cnt <= '0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run && !err) state_q <= S_FETCH;
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          op_q    <= op_t'(instr[OP_HI:OP_LO]);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (op_q)
            OP_ADD: state_q <= S_WB;
            OP_LD, OP_ST: begin
              wait_cnt <= '0;
              state_q  <= S_MEM;
            end
            default: begin
              retired <= retired + CNT_W'(1);
              state_q <= after_complete(run);
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_LD) begin
              state_q <= S_WB;
            end else begin
              retired <= retired + CNT_W'(1);
              state_q <= after_complete(run);
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort without retiring; err holds off fetches until reset
            err     <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired <= retired + CNT_W'(1);
          state_q <= after_complete(run);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  ctrl_decode u_decode (
    .state (state_q),
    .op_q  (op_q),
    .strb  (strb)
  );

  assign ir_write = strb.ir_write;
  assign pc_write = strb.pc_write;
  assign pc_src   = strb.pc_src;
  assign alusrc   = strb.alusrc;
  assign regdst   = strb.regdst;
  assign regwrite = strb.regwrite;
  assign memread  = strb.memread;
  assign memwrite = strb.memwrite;
  assign memtoreg = strb.memtoreg;
  assign busy     = (state_q != S_IDLE);
  assign state    = state_q;

endmodule
